// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one W-bit 2:1 mux datapath into a registered output stage.
// Optional packet lock is enabled by defining MUX_ARB_LOCK_EN.

module mux_2to1 (
  input  logic i0,
  input  logic i1,
  input  logic s,
  output logic y
);
  assign y = s ? i1 : i0;
endmodule

module mux2_rr_arbiter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  input  logic         req0_last,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  input  logic         req1_last,
  output logic         req1_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         out_src,
  input  logic         out_ready,
  output logic         grant_sel
);

  typedef enum logic [1:0] {
    S_FREE  = 2'd0,
    S_LOCK0 = 2'd1,
    S_LOCK1 = 2'd2
  } state_t;

  state_t       state;
  logic         prio;
  logic         load_en;
  logic         accept;
  logic         acc_last;
  logic [W-1:0] mux_data;

  always_comb begin
    grant_sel = prio;
    case (state)
      S_LOCK0: grant_sel = 1'b0;
      S_LOCK1: grant_sel = 1'b1;
      default: begin
        if (req0_valid && !req1_valid)
          grant_sel = 1'b0;
        else if (req1_valid && !req0_valid)
          grant_sel = 1'b1;
        else
          grant_sel = prio;
      end
    endcase
  end

  assign load_en    = !out_valid || out_ready;
  assign req0_ready = !rst && load_en && req0_valid && !grant_sel;
  assign req1_ready = !rst && load_en && req1_valid &&  grant_sel;
  assign accept     = req0_ready || req1_ready;
  assign acc_last   = grant_sel ? req1_last : req0_last;

  for (genvar i = 0; i < W; i++) begin : g_slice
    mux_2to1 u_mux (
      .i0 (req0_data[i]),
      .i1 (req1_data[i]),
      .s  (grant_sel),
      .y  (mux_data[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
      prio      <= 1'b0;
      state     <= S_FREE;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_last  <= acc_last;
        out_src   <= grant_sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

`ifdef MUX_ARB_LOCK_EN
      // Priority only rotates when a packet completes; mid-packet beats hold the lock.
      if (accept) begin
        case (state)
          S_FREE: begin
            if (acc_last)
              prio <= !grant_sel;
            else
              state <= grant_sel ? S_LOCK1 : S_LOCK0;
          end
          default: begin
            if (acc_last) begin
              state <= S_FREE;
              prio  <= !grant_sel;
            end
          end
        endcase
      end
`else
      state <= S_FREE;
      if (accept)
        prio <= !grant_sel;
`endif
    end
  end

  a_one_ready : assert property (@(posedge clk) !(req0_ready && req1_ready));
  a_hold : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_src)));

endmodule
